// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding (common to master and slave) and bus constants.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } i2c_state_t;

  localparam logic [6:0] GENERAL_CALL_ADDR = 7'h00;
  localparam int         SYNC_STAGES       = 2;
  localparam logic [3:0] BYTE_BITS         = 4'd8;

  // States in which the slave owns the current transfer.
  function automatic logic state_is_active(input i2c_state_t s);
    return (s == ADDR_ACK) || (s == WRITE) || (s == WRITE_ACK) ||
           (s == READ) || (s == READ_ACK);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus one delay stage for SCL edge and START/STOP detection.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_dly;
  logic                   r_sda_dly;

  // Idle bus level is high on both lines, so reset to 1 to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_dly  <= 1'b1;
      r_sda_dly  <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_dly  <= r_scl_sync[SYNC_STAGES-1];
      r_sda_dly  <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl       = r_scl_sync[SYNC_STAGES-1];
  assign sda       = r_sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl & ~r_scl_dly;
  assign scl_fall  = ~scl &  r_scl_dly;
  assign start_det =  scl &  r_scl_dly & ~sda &  r_sda_dly;
  assign stop_det  =  scl &  r_scl_dly &  sda & ~r_sda_dly;

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave byte engine: address match, write receive, read transmit, ACK handling.
// Optional: define I2C_SLAVE_GENERAL_CALL_EN to also accept general-call writes (addr 7'h00).
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl       (w_scl),
    .sda       (w_sda),
    .scl_rise  (w_scl_rise),
    .scl_fall  (w_scl_fall),
    .start_det (w_start),
    .stop_det  (w_stop)
  );

  i2c_state_t r_state, w_state_nxt;
  logic [3:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_txsh, w_txsh_nxt;
  logic [7:0] r_rx_data, w_rx_data_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_mack, w_mack_nxt;
  logic       r_sda_oe, w_oe_nxt;
  logic       r_rx_valid, w_rx_valid_nxt;
  logic       r_tx_req, w_tx_req_nxt;
  logic       r_busy, w_busy_nxt;
  logic       w_is_gc, w_addr_hit, w_oe_ok;

  assign w_is_gc = (r_shift[7:1] == GENERAL_CALL_ADDR);

  always_comb begin
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    // General call is write-only; a general-call read is never acknowledged.
    w_addr_hit = w_is_gc ? ~r_shift[0] : (r_shift[7:1] == SLAVE_ADDR);
`else
    w_addr_hit = ~w_is_gc & (r_shift[7:1] == SLAVE_ADDR);
`endif
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_txsh_nxt     = r_txsh;
    w_rx_data_nxt  = r_rx_data;
    w_rw_nxt       = r_rw;
    w_mack_nxt     = r_mack;
    w_oe_nxt       = r_sda_oe;
    w_rx_valid_nxt = 1'b0;
    w_tx_req_nxt   = 1'b0;
    w_busy_nxt     = state_is_active(r_state);
    if (w_stop) begin
      w_state_nxt = IDLE;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = ADDR;
      w_bitcnt_nxt = 4'd0;
      w_oe_nxt     = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE, WAIT_STOP: begin
          w_oe_nxt   = 1'b0;
          w_busy_nxt = 1'b0;
        end
        ADDR: begin
          if (w_scl_rise && r_bitcnt < BYTE_BITS) begin
            w_shift_nxt  = {r_shift[6:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt == BYTE_BITS) begin
            if (w_addr_hit) begin
              w_state_nxt = ADDR_ACK;
              w_oe_nxt    = 1'b1;
              w_busy_nxt  = 1'b1;
              w_rw_nxt    = r_shift[0];
            end else begin
              w_state_nxt = WAIT_STOP;
              w_busy_nxt  = 1'b0;
            end
          end
        end
        ADDR_ACK: begin
          if (w_scl_fall) begin
            w_bitcnt_nxt = 4'd0;
            if (r_rw) begin
              w_state_nxt  = READ;
              w_txsh_nxt   = tx_data;
              w_tx_req_nxt = 1'b1;
              w_oe_nxt     = ~tx_data[7];
            end else begin
              w_state_nxt = WRITE;
              w_oe_nxt    = 1'b0;
            end
          end
        end
        WRITE: begin
          if (w_scl_rise && r_bitcnt < BYTE_BITS) begin
            w_shift_nxt  = {r_shift[6:0], w_sda};
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (r_bitcnt == BYTE_BITS - 4'd1) begin
              w_rx_data_nxt  = {r_shift[6:0], w_sda};
              w_rx_valid_nxt = 1'b1;
            end
          end else if (w_scl_fall && r_bitcnt == BYTE_BITS) begin
            w_state_nxt = WRITE_ACK;
            w_oe_nxt    = 1'b1;
          end
        end
        WRITE_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt  = WRITE;
            w_bitcnt_nxt = 4'd0;
            w_oe_nxt     = 1'b0;
          end
        end
        READ: begin
          if (w_scl_rise && r_bitcnt < BYTE_BITS) begin
            w_bitcnt_nxt = r_bitcnt + 4'd1;
          end else if (w_scl_fall && r_bitcnt != 4'd0) begin
            if (r_bitcnt == BYTE_BITS) begin
              w_state_nxt = READ_ACK;
              w_oe_nxt    = 1'b0;
            end else begin
              // Rotate so the next bit to send is always at [7].
              w_txsh_nxt = {r_txsh[6:0], r_txsh[7]};
              w_oe_nxt   = ~r_txsh[6];
            end
          end
        end
        READ_ACK: begin
          if (w_scl_rise) begin
            w_mack_nxt = w_sda;
          end else if (w_scl_fall) begin
            if (!r_mack) begin
              w_state_nxt  = READ;
              w_bitcnt_nxt = 4'd0;
              w_txsh_nxt   = tx_data;
              w_tx_req_nxt = 1'b1;
              w_oe_nxt     = ~tx_data[7];
            end else begin
              w_state_nxt = WAIT_STOP;
              w_oe_nxt    = 1'b0;
              w_busy_nxt  = 1'b0;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_oe_nxt    = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // SDA may only move while SCL is low, except for release on START/STOP.
  assign w_oe_ok = ~w_scl | w_start | w_stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_bitcnt   <= 4'd0;
      r_shift    <= 8'h00;
      r_txsh     <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rw       <= 1'b0;
      r_mack     <= 1'b1;
      r_sda_oe   <= 1'b0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_shift    <= w_shift_nxt;
      r_txsh     <= w_txsh_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rw       <= w_rw_nxt;
      r_mack     <= w_mack_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_req   <= w_tx_req_nxt;
      r_busy     <= w_busy_nxt;
      if (w_oe_ok) r_sda_oe <= w_oe_nxt;
    end
  end

  assign sda_oe   = r_sda_oe;
  assign tx_req   = r_tx_req;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bit-banged master, transaction-level reference model, pulse scoreboard.
module tb_i2c_slave_ctrl;

  localparam int         Q     = 6;
  localparam logic [6:0] SA    = 7'h42;
  localparam int         EV_RX = 0;
  localparam int         EV_TX = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_bus;
  logic       sda_oe, tx_req, rx_valid, busy;
  logic [7:0] rx_data;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_ctrl #(.SLAVE_ADDR(SA)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  ev_t        sb[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] last_rx = 8'h00;
  logic [7:0] pay[4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  // Monitor: every DUT pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (rx_valid || tx_req)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pulse: rx_valid=%0b tx_req=%0b with empty scoreboard", rx_valid, tx_req);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (rx_valid) begin
          chk("rx_event_kind", EV_RX, e.kind);
          chk("rx_event_data", rx_data, e.val);
        end else begin
          chk("tx_event_kind", EV_TX, e.kind);
        end
      end
    end
  end

  // Reference: which address bytes the slave acknowledges.
  function automatic bit model_match(input logic [7:0] ab);
    if (ab[7:1] == 7'h00) begin
`ifdef I2C_SLAVE_GENERAL_CALL_EN
      return !ab[0];
`else
      return 1'b0;
`endif
    end
    return ab[7:1] == SA;
  endfunction

  task automatic q_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_c();
    sda_m = 1'b1; scl_m = 1'b1; q_wait(Q);
    sda_m = 1'b0; q_wait(Q);
    scl_m = 1'b0; q_wait(Q);
  endtask

  task automatic rep_start();
    sda_m = 1'b1; q_wait(Q);
    scl_m = 1'b1; q_wait(Q);
    sda_m = 1'b0; q_wait(Q);
    scl_m = 1'b0; q_wait(Q);
  endtask

  task automatic stop_c();
    sda_m = 1'b0; q_wait(Q);
    scl_m = 1'b1; q_wait(Q);
    sda_m = 1'b1; q_wait(Q);
  endtask

  task automatic bit_io(input logic b, output logic rd);
    sda_m = b; q_wait(Q);
    scl_m = 1'b1; q_wait(Q);
    rd = sda_bus; q_wait(Q);
    scl_m = 1'b0; q_wait(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic unused_rd;
    for (int i = 7; i >= 0; i--) bit_io(d[i], unused_rd);
    bit_io(1'b1, ack);
  endtask

  // rst_bit >= 0 pulses rst while SCL is high during that bit (0 = MSB).
  task automatic read_byte(input int rst_bit, output logic [7:0] v);
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; q_wait(Q);
      scl_m = 1'b1; q_wait(Q);
      v = {v[6:0], sda_bus};
      if (i == rst_bit) begin
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("oe_after_rst", sda_oe, 1'b0);
        rst = 1'b0;
        last_rx = 8'h00;
      end
      q_wait(Q);
      scl_m = 1'b0; q_wait(Q);
    end
  endtask

  task automatic do_xfer(input logic [7:0] ab, input int n, input bit rep, input bit stop_after);
    bit         m;
    logic       ack;
    logic [7:0] v;
    m = model_match(ab);
    if (rep) rep_start(); else start_c();
    if (m && ab[0]) begin
      tx_data = pay[0];
      push_ev(EV_TX, pay[0]);
    end
    write_byte(ab, ack);
    chk("addr_ack", ack, !m);
    chk("busy_after_addr", busy, m);
    if (m && !ab[0]) begin
      for (int i = 0; i < n; i++) begin
        push_ev(EV_RX, pay[i]);
        write_byte(pay[i], ack);
        chk("data_ack", ack, 1'b0);
        last_rx = pay[i];
      end
    end else if (m) begin
      for (int i = 0; i < n; i++) begin
        read_byte(-1, v);
        chk("read_byte", v, pay[i]);
        if (i < n - 1) begin
          tx_data = pay[i+1];
          push_ev(EV_TX, pay[i+1]);
          bit_io(1'b0, ack);
        end else begin
          bit_io(1'b1, ack);
          chk("oe_after_nack", sda_oe, 1'b0);
          chk("busy_after_nack", busy, 1'b0);
        end
      end
    end
    if (stop_after) begin
      stop_c();
      q_wait(8);
      chk("busy_after_stop", busy, 1'b0);
      chk("oe_after_stop", sda_oe, 1'b0);
      chk("rx_data_after_stop", rx_data, last_rx);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ack;
    logic [7:0] v;
    bit         prev_stop;

    q_wait(4);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_tx_req", tx_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    q_wait(4);

    pay[0] = 8'hA5; do_xfer(8'h84, 1, 1'b0, 1'b1);
    pay[0] = 8'h3C; do_xfer(8'h85, 1, 1'b0, 1'b1);
    pay[0] = 8'h99; do_xfer(8'hA0, 1, 1'b0, 1'b1);
    pay[0] = 8'h11; do_xfer(8'h84, 1, 1'b0, 1'b0);
    pay[0] = 8'h5A; pay[1] = 8'hC3; do_xfer(8'h85, 2, 1'b1, 1'b1);

    // Reset in the middle of a read byte whose bits all pull SDA low.
    start_c();
    tx_data = 8'h00;
    push_ev(EV_TX, 8'h00);
    write_byte(8'h85, ack);
    chk("rstread_addr_ack", ack, 1'b0);
    read_byte(3, v);
    bit_io(1'b1, ack);
    stop_c();
    q_wait(4);
    chk("rx_data_after_midrst", rx_data, 8'h00);
    chk("busy_after_midrst", busy, 1'b0);
    pay[0] = 8'h77; do_xfer(8'h84, 1, 1'b0, 1'b1);

    pay[0] = 8'h06; do_xfer(8'h00, 1, 1'b0, 1'b1);
    pay[0] = 8'hE1; do_xfer(8'h01, 1, 1'b0, 1'b1);

    prev_stop = 1'b1;
    for (int t = 0; t < 24; t++) begin
      logic [7:0] ab;
      int         sel, n;
      bit         stp;
      sel = $urandom_range(0, 3);
      case (sel)
        0, 1:    ab = {SA, 1'($urandom_range(0, 1))};
        2:       ab = {7'h00, 1'($urandom_range(0, 1))};
        default: ab = 8'($urandom_range(0, 255));
      endcase
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) pay[k] = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 3) != 0);
      do_xfer(ab, n, !prev_stop, stp);
      prev_stop = stp;
    end
    if (!prev_stop) begin
      stop_c();
      q_wait(8);
      chk("final_busy", busy, 1'b0);
      chk("final_rx_data", rx_data, last_rx);
    end

    q_wait(20);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
